// File: rtl/a23_shift_pkg.sv
// Shared shift-type codes, widths and data-source selector for the A23 shift stage.
package a23_shift_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned AMT_W  = 8;
    localparam int unsigned ROT_W  = 5;

    // Plain codes rather than an enum so reserved values 5-7 stay representable.
    localparam logic [TYPE_W-1:0] SH_LSL = 3'd0;
    localparam logic [TYPE_W-1:0] SH_LSR = 3'd1;
    localparam logic [TYPE_W-1:0] SH_ASR = 3'd2;
    localparam logic [TYPE_W-1:0] SH_ROR = 3'd3;
    localparam logic [TYPE_W-1:0] SH_RRX = 3'd4;

    typedef enum logic [1:0] {
        SrcOp,
        SrcRot,
        SrcFill,
        SrcRrx
    } sh_src_e;

endpackage

// File: rtl/a23_shift_stage_if.sv
// Request, rotator and result signals of the A23 shift stage.
interface a23_shift_stage_if;
    import a23_shift_pkg::*;

    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_operand;
    logic [TYPE_W-1:0] i_type;
    logic [AMT_W-1:0]  i_amount;
    logic              i_carry;
    logic [DATA_W-1:0] o_rot_in;
    logic              o_rot_left;
    logic [ROT_W-1:0]  o_rot_amt;
    logic [DATA_W-1:0] i_rot_prod;
    logic              o_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_result;
    logic              o_carry;

    modport slave (
        input  i_valid, i_operand, i_type, i_amount, i_carry, i_rot_prod, i_out_ready,
        output o_ready, o_rot_in, o_rot_left, o_rot_amt, o_valid, o_result, o_carry
    );

    modport master (
        output i_valid, i_operand, i_type, i_amount, i_carry, i_rot_prod, i_out_ready,
        input  o_ready, o_rot_in, o_rot_left, o_rot_amt, o_valid, o_result, o_carry
    );

endinterface

// File: rtl/a23_shift_mask.sv
// Mask, fill bit and data-source selection applied to the external rotator product.
module a23_shift_mask
    import a23_shift_pkg::*;
(
    input  logic [TYPE_W-1:0] sh_type_i,
    input  logic [AMT_W-1:0]  amount_i,
    input  logic              sign_i,
    output logic [DATA_W-1:0] mask_o,
    output logic              fill_o,
    output sh_src_e           src_o
);

    logic amt_zero;
    logic amt_short;

    assign amt_zero  = (amount_i == '0);
    assign amt_short = !amt_zero && (amount_i[7:5] == 3'b000);

    always_comb begin
        mask_o = '1;
        fill_o = 1'b0;
        src_o  = SrcOp;
        case (sh_type_i)
            SH_LSL: begin
                if (amt_short) begin
                    src_o  = SrcRot;
                    mask_o = {DATA_W{1'b1}} << amount_i[4:0];
                end else if (!amt_zero) begin
                    src_o = SrcFill;
                end
            end
            SH_LSR, SH_ASR: begin
                fill_o = (sh_type_i == SH_ASR) ? sign_i : 1'b0;
                if (amt_short) begin
                    src_o  = SrcRot;
                    mask_o = {DATA_W{1'b1}} >> amount_i[4:0];
                end else if (!amt_zero) begin
                    src_o = SrcFill;
                end
            end
            // Multiples of 32 leave the operand unchanged, so only real rotations use the product.
            SH_ROR: begin
                if (amount_i[4:0] != 5'd0) begin
                    src_o = SrcRot;
                end
            end
            SH_RRX: src_o = SrcRrx;
            default: src_o = SrcOp;
        endcase
    end

endmodule

// File: rtl/a23_shift_stage.sv
// Two-stage barrel-shift stage: S1 holds the request and drives the external rotator,
// S2 registers the masked/filled result and carry-out.
module a23_shift_stage
    import a23_shift_pkg::*;
(
    input logic             i_clk,
    input logic             i_rst_n,
    a23_shift_stage_if.slave bus
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_op;
    logic [TYPE_W-1:0] s1_type;
    logic [AMT_W-1:0]  s1_amount;
    logic              s1_cin;

    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic              out_carry;

    logic              s2_load;
    logic              accept;
    logic              s1_zero;
    logic              s1_short;
    logic [DATA_W-1:0] mask;
    logic              fill;
    sh_src_e           src;
    logic [DATA_W-1:0] result_d;
    logic              carry_d;

    assign s2_load     = s1_valid && (!out_valid || bus.i_out_ready);
    assign bus.o_ready = i_rst_n && (!s1_valid || s2_load);
    assign accept      = bus.i_valid && bus.o_ready;

    assign bus.o_rot_in   = s1_op;
    assign bus.o_rot_left = (s1_type == SH_LSL);
    assign bus.o_rot_amt  = s1_amount[4:0];

    assign bus.o_valid  = out_valid;
    assign bus.o_result = out_result;
    assign bus.o_carry  = out_carry;

    assign s1_zero  = (s1_amount == '0);
    assign s1_short = !s1_zero && (s1_amount[7:5] == 3'b000);

    a23_shift_mask u_mask (
        .sh_type_i (s1_type),
        .amount_i  (s1_amount),
        .sign_i    (s1_op[DATA_W-1]),
        .mask_o    (mask),
        .fill_o    (fill),
        .src_o     (src)
    );

    always_comb begin
        result_d = s1_op;
        unique case (src)
            SrcRot:  result_d = (bus.i_rot_prod & mask) | (~mask & {DATA_W{fill}});
            SrcFill: result_d = {DATA_W{fill}};
            SrcRrx:  result_d = {s1_cin, s1_op[DATA_W-1:1]};
            default: result_d = s1_op;
        endcase
    end

    // The last bit shifted out lands at product bit 0 (left) or bit 31 (right).
    always_comb begin
        carry_d = s1_cin;
        case (s1_type)
            SH_LSL: begin
                if (s1_short)                 carry_d = bus.i_rot_prod[0];
                else if (s1_amount == 8'd32)  carry_d = s1_op[0];
                else if (!s1_zero)            carry_d = 1'b0;
            end
            SH_LSR: begin
                if (s1_short)                 carry_d = bus.i_rot_prod[DATA_W-1];
                else if (s1_amount == 8'd32)  carry_d = s1_op[DATA_W-1];
                else if (!s1_zero)            carry_d = 1'b0;
            end
            SH_ASR: begin
                if (s1_short)                 carry_d = bus.i_rot_prod[DATA_W-1];
                else if (!s1_zero)            carry_d = s1_op[DATA_W-1];
            end
            SH_ROR: begin
                if (!s1_zero)                 carry_d = result_d[DATA_W-1];
            end
            SH_RRX:  carry_d = s1_op[0];
            default: carry_d = s1_cin;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_type    <= '0;
            s1_amount  <= '0;
            s1_cin     <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_op     <= bus.i_operand;
                s1_type   <= bus.i_type;
                s1_amount <= bus.i_amount;
                s1_cin    <= bus.i_carry;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                out_valid  <= 1'b1;
                out_result <= result_d;
                out_carry  <= carry_d;
            end else if (bus.i_out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_a23_shift_stage.sv
// Scoreboard bench for a23_shift_stage with an external rotator model and random backpressure.
module tb_a23_shift_stage;
    import a23_shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    a23_shift_stage_if bus();

    a23_shift_stage dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int mode = 2;       // 0 random, 1 pattern 1,0,0, 2 always ready, 3 never ready
    int pat_cnt = 0;
    bit mon_en = 1'b0;
    logic [32:0] exp_q[$];

    function automatic logic [31:0] rotate(input logic [31:0] x, input logic left, input int a);
        if (a == 0) return x;
        if (left) return (x << a) | (x >> (32 - a));
        return (x >> a) | (x << (32 - a));
    endfunction

    assign bus.i_rot_prod = rotate(bus.o_rot_in, bus.o_rot_left, int'(bus.o_rot_amt));

    // Reference: {carry, result} straight from the shift rules.
    function automatic logic [32:0] ref_shift(input logic [31:0] op, input logic [2:0] t,
                                              input logic [7:0] n, input logic c);
        int k;
        int m;
        logic [31:0] r;
        logic co;
        logic [63:0] dbl;
        k = int'(n);
        r = op;
        co = c;
        case (t)
            3'd0: begin
                if (k >= 1 && k <= 31) begin r = op << k; co = op[32 - k]; end
                else if (k == 32) begin r = '0; co = op[0]; end
                else if (k > 32) begin r = '0; co = 1'b0; end
            end
            3'd1: begin
                if (k >= 1 && k <= 31) begin r = op >> k; co = op[k - 1]; end
                else if (k == 32) begin r = '0; co = op[31]; end
                else if (k > 32) begin r = '0; co = 1'b0; end
            end
            3'd2: begin
                if (k >= 1 && k <= 31) begin r = $unsigned($signed(op) >>> k); co = op[k - 1]; end
                else if (k >= 32) begin r = {32{op[31]}}; co = op[31]; end
            end
            3'd3: begin
                if (k != 0) begin
                    m = k % 32;
                    dbl = {op, op} >> m;
                    r = dbl[31:0];
                    co = r[31];
                end
            end
            3'd4: begin r = {c, op[31:1]}; co = op[0]; end
            default: begin r = op; co = c; end
        endcase
        return {co, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] op, input logic [2:0] t, input logic [7:0] n,
                        input logic c);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_operand = op;
        bus.i_type = t;
        bus.i_amount = n;
        bus.i_carry = c;
        forever begin
            #4;
            acc = bus.o_ready;
            @(posedge clk);
            if (acc) break;
            guard++;
            if (guard > 1000) begin
                errors++;
                $display("FAIL accept_timeout: got no o_ready expected accept within 1000 cycles");
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
        end
        exp_q.push_back(ref_shift(op, t, n, c));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Downstream backpressure.
    initial begin
        bus.i_out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                0: bus.i_out_ready = ($urandom_range(0, 9) < 7);
                1: begin bus.i_out_ready = (pat_cnt % 3 == 0); pat_cnt++; end
                2: bus.i_out_ready = 1'b1;
                default: bus.i_out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every transfer and checks outputs hold while stalled.
    initial begin
        bit held;
        logic [31:0] hr;
        logic hc;
        logic [32:0] e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!mon_en) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                chk("hold_valid", 32'(bus.o_valid), 32'd1);
                chk("hold_result", bus.o_result, hr);
                chk("hold_carry", 32'(bus.o_carry), 32'(hc));
            end
            held = 1'b0;
            if (bus.o_valid) begin
                if (!bus.i_out_ready) begin
                    held = 1'b1;
                    hr = bus.o_result;
                    hc = bus.o_carry;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", bus.o_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", bus.o_result, e[31:0]);
                    chk("carry", 32'(bus.o_carry), 32'(e[32]));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t;
        logic [7:0] n;
        int r;
        bus.i_valid = 1'b0;
        bus.i_operand = '0;
        bus.i_type = '0;
        bus.i_amount = '0;
        bus.i_carry = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_o_ready", 32'(bus.o_ready), 32'd0);
        chk("reset_o_result", bus.o_result, 32'd0);
        chk("reset_o_carry", 32'(bus.o_carry), 32'd0);
        chk("reset_rot_in", bus.o_rot_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(bus.o_ready), 32'd1);
        mon_en = 1'b1;

        // Latency: valid appears after the second edge.
        send(32'h8000_0001, SH_LSL, 8'd1, 1'b0);
        #1;
        chk("latency_edge1", 32'(bus.o_valid), 32'd0);
        idle();
        @(posedge clk);
        #1;
        chk("latency_edge2", 32'(bus.o_valid), 32'd1);
        chk("lsl1_result", bus.o_result, 32'h0000_0002);
        chk("lsl1_carry", 32'(bus.o_carry), 32'd1);
        drain();

        send(32'h8000_0000, SH_ASR, 8'd40, 1'b0);
        send(32'h8000_0000, SH_LSR, 8'd32, 1'b0);
        send(32'h0000_00F1, SH_ROR, 8'd4, 1'b1);
        send(32'h0000_00F1, SH_ROR, 8'd32, 1'b1);
        send(32'h0000_0001, SH_RRX, 8'd77, 1'b1);
        send(32'h1234_5678, 3'd6, 8'd5, 1'b1);
        send(32'h8000_0001, SH_LSL, 8'd32, 1'b0);
        send(32'h8000_0001, SH_LSL, 8'd33, 1'b1);
        send(32'h4000_0000, SH_LSR, 8'd0, 1'b1);
        idle();
        drain();

        // Back-to-back with ready pattern 1,0,0.
        pat_cnt = 0;
        mode = 1;
        for (int i = 0; i < 8; i++) begin
            send($urandom, 3'($urandom_range(0, 4)), 8'($urandom_range(1, 31)), 1'($urandom));
        end
        idle();
        drain();

        // Reset with both stages full.
        mode = 3;
        @(negedge clk);
        mon_en = 1'b0;
        send(32'hDEAD_BEEF, SH_LSR, 8'd4, 1'b0);
        send(32'hCAFE_F00D, SH_LSL, 8'd8, 1'b0);
        #1;
        chk("full_o_valid", 32'(bus.o_valid), 32'd1);
        chk("full_o_ready", 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_o_valid", 32'(bus.o_valid), 32'd0);
        chk("midreset_o_ready", 32'(bus.o_ready), 32'd0);
        chk("midreset_o_result", bus.o_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        chk("rerelease_o_ready", 32'(bus.o_ready), 32'd1);
        mode = 2;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_stale_o_valid", 32'(bus.o_valid), 32'd0);

        // Random traffic.
        mode = 0;
        for (int i = 0; i < 10000; i++) begin
            r = $urandom_range(0, 15);
            t = (r < 13) ? 3'(r % 5) : 3'(r - 8);
            case ($urandom_range(0, 7))
                0: n = 8'd0;
                1: n = 8'd32;
                2: n = 8'($urandom_range(33, 255));
                3: n = ($urandom_range(0, 1) != 0) ? 8'd31 : 8'd1;
                4: n = 8'($urandom_range(1, 7) * 32);
                default: n = 8'($urandom_range(1, 31));
            endcase
            send($urandom, t, n, 1'($urandom));
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
